// File: rtl/mac_stream_feeder.sv
// Producer-side controller for the pipelined saturating MAC: streams operand pairs in,
// counts returning valid_out pulses, captures the dot product and clears the MAC.
module mac_stream_feeder #(
    parameter int unsigned WIDTH      = 14,
    parameter int unsigned ACC_WIDTH  = 28,
    parameter int unsigned LEN_WIDTH  = 8,
    parameter int unsigned CLR_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     s_a,
    input  logic [WIDTH-1:0]     s_b,
    input  logic                 s_valid,
    input  logic                 s_last,
    output logic                 s_ready,
    output logic [WIDTH-1:0]     mac_a,
    output logic [WIDTH-1:0]     mac_b,
    output logic                 mac_valid_in,
    output logic                 mac_clear,
    input  logic [ACC_WIDTH-1:0] mac_f,
    input  logic                 mac_valid_out,
    output logic [ACC_WIDTH-1:0] r_data,
    output logic [LEN_WIDTH-1:0] r_count,
    output logic                 r_sat,
    output logic                 r_valid,
    input  logic                 r_ready
);

    localparam int unsigned CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam logic [CLR_W-1:0]     CLR_LAST   = CLR_W'(CLR_CYCLES - 1);
    localparam logic [LEN_WIDTH-1:0] LAST_ISSUE = {{(LEN_WIDTH-1){1'b1}}, 1'b0};
    localparam logic [ACC_WIDTH-1:0] SAT_POS    = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] SAT_NEG    = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FEED  = 3'd1,
        DRAIN = 3'd2,
        CLEAR = 3'd3,
        HOLD  = 3'd4
    } state_t;

    state_t               state;
    logic [CLR_W-1:0]     clr_cnt;
    logic [LEN_WIDTH-1:0] issued;
    logic [LEN_WIDTH-1:0] returned;

    logic                 accept;
    logic                 last_eff;
    logic [LEN_WIDTH-1:0] returned_inc;
    logic                 drain_done;

    assign s_ready      = (state == IDLE) || (state == FEED);
    assign accept       = s_valid & s_ready;
    // The counter would overflow on the next pair, so force the vector to end here.
    assign last_eff     = s_last | (issued == LAST_ISSUE);
    assign returned_inc = returned + LEN_WIDTH'(1);
    assign drain_done   = (returned == issued) || (mac_valid_out && (returned_inc == issued));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= CLEAR;
            clr_cnt      <= '0;
            issued       <= '0;
            returned     <= '0;
            mac_clear    <= 1'b1;
            mac_valid_in <= 1'b0;
            mac_a        <= '0;
            mac_b        <= '0;
            r_valid      <= 1'b0;
            r_data       <= '0;
            r_count      <= '0;
            r_sat        <= 1'b0;
        end else begin
            mac_valid_in <= 1'b0;
            if (r_valid && r_ready) begin
                r_valid <= 1'b0;
            end
            case (state)
                IDLE, FEED: begin
                    if (mac_valid_out) begin
                        returned <= returned_inc;
                    end
                    if (accept) begin
                        mac_a        <= s_a;
                        mac_b        <= s_b;
                        mac_valid_in <= 1'b1;
                        issued       <= issued + LEN_WIDTH'(1);
                        state        <= last_eff ? DRAIN : FEED;
                    end
                end
                DRAIN: begin
                    if (mac_valid_out) begin
                        returned <= returned_inc;
                    end
                    // Final pulse carries the complete accumulator value.
                    if (drain_done) begin
                        r_valid   <= 1'b1;
                        r_data    <= mac_f;
                        r_count   <= issued;
                        r_sat     <= (mac_f == SAT_POS) || (mac_f == SAT_NEG);
                        mac_clear <= 1'b1;
                        clr_cnt   <= '0;
                        issued    <= '0;
                        returned  <= '0;
                        state     <= CLEAR;
                    end
                end
                CLEAR: begin
                    issued   <= '0;
                    returned <= '0;
                    if (clr_cnt == CLR_LAST) begin
                        mac_clear <= 1'b0;
                        clr_cnt   <= '0;
                        state     <= (r_valid && !r_ready) ? HOLD : IDLE;
                    end else begin
                        clr_cnt <= clr_cnt + CLR_W'(1);
                    end
                end
                HOLD: begin
                    if (r_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    mac_clear <= 1'b1;
                    clr_cnt   <= '0;
                    state     <= CLEAR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_stream_feeder.sv
// Directed bench for mac_stream_feeder with a behavioural 4-cycle saturating MAC
// attached to its MAC-side ports.
module tb_mac_stream_feeder;

    logic               clk = 1'b0;
    logic               reset;
    logic [13:0]        s_a, s_b;
    logic               s_valid, s_last, s_ready;
    logic [13:0]        mac_a, mac_b;
    logic               mac_valid_in, mac_clear;
    logic [27:0]        mac_f;
    logic               mac_valid_out;
    logic [27:0]        r_data;
    logic [7:0]         r_count;
    logic               r_sat, r_valid, r_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mac_stream_feeder #(
        .WIDTH(14), .ACC_WIDTH(28), .LEN_WIDTH(8), .CLR_CYCLES(3)
    ) dut (
        .clk(clk), .reset(reset),
        .s_a(s_a), .s_b(s_b), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .mac_a(mac_a), .mac_b(mac_b), .mac_valid_in(mac_valid_in), .mac_clear(mac_clear),
        .mac_f(mac_f), .mac_valid_out(mac_valid_out),
        .r_data(r_data), .r_count(r_count), .r_sat(r_sat), .r_valid(r_valid),
        .r_ready(r_ready)
    );

    // Saturating MAC: 4-cycle valid_in to valid_out, synchronous active-high clear.
    logic [2:0]          pv;
    logic signed [27:0]  pp0, pp1, pp2, acc;
    logic signed [28:0]  sum;

    assign sum   = {acc[27], acc} + {pp2[27], pp2};
    assign mac_f = acc;

    function automatic logic signed [27:0] sat28(input logic signed [28:0] v);
        if (v > 29'sd134217727)       return 28'sd134217727;
        else if (v < -29'sd134217728) return -28'sd134217728;
        else                          return 28'(v);
    endfunction

    always_ff @(posedge clk) begin
        if (mac_clear) begin
            pv            <= '0;
            pp0           <= '0;
            pp1           <= '0;
            pp2           <= '0;
            acc           <= '0;
            mac_valid_out <= 1'b0;
        end else begin
            pv            <= {pv[1:0], mac_valid_in};
            pp0           <= 28'($signed(mac_a)) * 28'($signed(mac_b));
            pp1           <= pp0;
            pp2           <= pp1;
            mac_valid_out <= pv[2];
            if (pv[2]) acc <= sat28(sum);
        end
    end

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge with s_valid low.
    task automatic push(input logic signed [13:0] a, input logic signed [13:0] b, input logic last);
        int n = 0;
        while (!s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("s_ready_wait", s_ready, 1);
        s_valid = 1'b1;
        s_a     = a;
        s_b     = b;
        s_last  = last;
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk("mac_valid_in", mac_valid_in, 1);
        chk("mac_a", $signed(mac_a), a);
        chk("mac_b", $signed(mac_b), b);
    endtask

    task automatic wait_result(input logic signed [63:0] data, input logic [63:0] cnt, input logic sat);
        int n = 0;
        while (!r_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("r_valid_wait", r_valid, 1);
        chk("r_data", $signed(r_data), data);
        chk("r_count", r_count, cnt);
        chk("r_sat", r_sat, sat);
    endtask

    // Counts consecutive sampled cycles with mac_clear high, starting at the current negedge.
    task automatic measure_clear(input logic [63:0] exp_len);
        int n = 0;
        while (mac_clear && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("clear_len", n, exp_len);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed running expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_a     = '0;
        s_b     = '0;
        r_ready = 1'b1;

        // Bring-up
        repeat (2) @(negedge clk);
        chk("rst_mac_clear", mac_clear, 1);
        chk("rst_mac_valid_in", mac_valid_in, 0);
        chk("rst_mac_a", mac_a, 0);
        chk("rst_mac_b", mac_b, 0);
        chk("rst_r_valid", r_valid, 0);
        chk("rst_r_data", r_data, 0);
        chk("rst_r_count", r_count, 0);
        chk("rst_r_sat", r_sat, 0);
        chk("rst_s_ready", s_ready, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("bringup_clear1", mac_clear, 1);
        @(negedge clk);
        chk("bringup_clear2", mac_clear, 1);
        @(negedge clk);
        chk("bringup_clear_done", mac_clear, 0);
        chk("bringup_s_ready", s_ready, 1);
        chk("bringup_r_valid", r_valid, 0);

        // 2*3 + 4*5 + (-1)*6 = 20
        push(2, 3, 0);
        push(4, 5, 0);
        push(-1, 6, 1);
        wait_result(20, 3, 0);
        measure_clear(3);
        chk("v1_s_ready", s_ready, 1);
        chk("v1_r_valid_taken", r_valid, 0);

        // Single element, then a fresh vector proves the MAC was cleared
        push(-8192, -8192, 1);
        wait_result(67108864, 1, 0);
        measure_clear(3);
        push(1, 1, 1);
        wait_result(1, 1, 0);
        measure_clear(3);

        // Positive saturation
        for (int i = 0; i < 5; i++) push(8191, 8191, (i == 4));
        wait_result(134217727, 5, 1);
        measure_clear(3);

        // Bubbles on input, result back-pressured: 1*2 + 3*4 + 5*6 = 44
        r_ready = 1'b0;
        push(1, 2, 0);
        @(negedge clk);
        push(3, 4, 0);
        @(negedge clk);
        push(5, 6, 1);
        wait_result(44, 3, 0);
        for (int i = 0; i < 10; i++) begin
            chk("bp_r_valid", r_valid, 1);
            chk("bp_r_data", $signed(r_data), 44);
            chk("bp_s_ready", s_ready, 0);
            @(negedge clk);
        end
        chk("bp_mac_clear_done", mac_clear, 0);
        r_ready = 1'b1;
        @(negedge clk);
        chk("bp_r_valid_taken", r_valid, 0);
        chk("bp_s_ready_back", s_ready, 1);
        push(2, 2, 1);
        wait_result(4, 1, 0);
        measure_clear(3);

        // Reset while draining aborts the vector
        push(1, 1, 0);
        push(2, 2, 0);
        push(3, 3, 1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("abort_r_valid", r_valid, 0);
        chk("abort_s_ready", s_ready, 0);
        measure_clear(3);
        for (int i = 0; i < 6; i++) begin
            chk("abort_no_result", r_valid, 0);
            @(negedge clk);
        end
        push(7, 7, 1);
        wait_result(49, 1, 0);
        measure_clear(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
